// File: rtl/alu_seq.sv
// Byte-serial instruction sequencer for the 8-bit ALU: collects opcode/register/immediate,
// issues the operation for one cycle, writes the result back and offers it on a writeback handshake.
module alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] alu_opcode,
    output logic [DATA_W-1:0] alu_operand_0,
    output logic [DATA_W-1:0] alu_operand_1,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [1:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    output logic              illegal,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [DATA_W-1:0] OPC_SUB_IMM = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] OPC_ADD_IMM = DATA_W'(8'h03);

    typedef enum logic [2:0] {
        S_OPC,
        S_REG,
        S_IMM,
        S_EXEC,
        S_WB
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_opc;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_rf [4];
    logic              r_in_ready;
    logic [DATA_W-1:0] r_alu_opcode;
    logic [DATA_W-1:0] r_alu_op0;
    logic [DATA_W-1:0] r_alu_op1;
    logic              r_wb_valid;
    logic [1:0]        r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_illegal;
    logic              w_in_xfer;

    assign w_in_xfer = in_valid && r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_OPC;
            r_opc        <= '0;
            r_idx        <= '0;
            for (int i = 0; i < 4; i++) r_rf[i] <= '0;
            r_in_ready   <= 1'b1;
            r_alu_opcode <= '0;
            r_alu_op0    <= '0;
            r_alu_op1    <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_reg     <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_OPC: begin
                    if (w_in_xfer) begin
                        if (in_data == OPC_ADD_IMM || in_data == OPC_SUB_IMM) begin
                            r_opc   <= in_data;
                            r_state <= S_REG;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_REG: begin
                    if (w_in_xfer) begin
                        if (in_data[DATA_W-1:2] == '0) begin
                            r_idx   <= in_data[1:0];
                            r_state <= S_IMM;
                        end else begin
                            r_illegal <= 1'b1;
                            r_opc     <= '0;
                            r_state   <= S_OPC;
                        end
                    end
                end
                S_IMM: begin
                    // ALU drive is loaded here so it is already registered throughout S_EXEC
                    if (w_in_xfer) begin
                        r_alu_opcode <= r_opc;
                        r_alu_op0    <= r_rf[r_idx];
                        r_alu_op1    <= in_data;
                        r_in_ready   <= 1'b0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rf[r_idx]  <= alu_result;
                    r_wb_reg     <= r_idx;
                    r_wb_data    <= alu_result;
                    r_wb_valid   <= 1'b1;
                    r_alu_opcode <= '0;
                    r_alu_op0    <= '0;
                    r_alu_op1    <= '0;
                    r_state      <= S_WB;
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_OPC;
                    end
                end
                default: r_state <= S_OPC;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign alu_opcode    = r_alu_opcode;
    assign alu_operand_0 = r_alu_op0;
    assign alu_operand_1 = r_alu_op1;
    assign wb_valid      = r_wb_valid;
    assign wb_reg        = r_wb_reg;
    assign wb_data       = r_wb_data;
    assign illegal       = r_illegal;
    assign dbg_data      = r_rf[dbg_sel];

endmodule
